// File: rtl/fir_pkg.sv
// Shared constants and the output round/saturate stage for the pipelined FIR.
// The helper works at a fixed wide width so any accumulator up to MaxW bits fits without overflow.
package fir_pkg;

  localparam int unsigned DefTaps     = 102;
  localparam int unsigned DefDinW     = 16;
  localparam int unsigned DefCoefW    = 32;
  localparam int unsigned DefAccW     = 64;
  localparam int unsigned DefOutShift = 32;
  localparam int unsigned DefDoutW    = 32;
  localparam int unsigned MaxW        = 128;

  typedef struct packed {
    logic                   sat;
    logic signed [MaxW-1:0] val;
  } rs_t;

  // Round half toward +inf, arithmetic shift, then clamp to a dout_w-bit signed range.
  function automatic rs_t round_sat(input logic signed [MaxW-1:0] acc,
                                    input int unsigned shift,
                                    input int unsigned dout_w);
    logic signed [MaxW-1:0] t;
    logic signed [MaxW-1:0] hi;
    logic signed [MaxW-1:0] lo;
    rs_t r;
    t = acc;
    if (shift != 0) t = t + (MaxW'(1) << (shift - 1));
    t  = t >>> shift;
    hi = (MaxW'(1) << (dout_w - 1)) - MaxW'(1);
    lo = ~hi;
    r.sat = 1'b0;
    r.val = t;
    if (t > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (t < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_pipelined_param_if.sv
// Sample, coefficient-load and result signals of the pipelined FIR.
// master drives samples and coefficients; slave is the filter side.
interface fir_pipelined_param_if #(
  parameter int unsigned TAPS   = fir_pkg::DefTaps,
  parameter int unsigned DIN_W  = fir_pkg::DefDinW,
  parameter int unsigned COEF_W = fir_pkg::DefCoefW,
  parameter int unsigned DOUT_W = fir_pkg::DefDoutW
) ();

  localparam int unsigned AW = $clog2(TAPS);

  logic                     in_valid;
  logic signed [DIN_W-1:0]  din;
  logic                     clear;
  logic                     coef_we;
  logic        [AW-1:0]     coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_commit;
  logic                     out_valid;
  logic signed [DOUT_W-1:0] dout;
  logic                     sat_flag;

  modport master (
    output in_valid, din, clear, coef_we, coef_addr, coef_wdata, coef_commit,
    input  out_valid, dout, sat_flag
  );

  modport slave (
    input  in_valid, din, clear, coef_we, coef_addr, coef_wdata, coef_commit,
    output out_valid, dout, sat_flag
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, commit copies it to the
// active bank which is read in parallel by every tap.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = DefTaps,
  parameter int unsigned COEF_W = DefCoefW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(TAPS)-1:0]  addr_i,
  input  logic signed [COEF_W-1:0] wdata_i,
  input  logic                     commit_i,
  output logic signed [COEF_W-1:0] coef_o [TAPS]
);

  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] active_q [TAPS];

  // Commit copies the pre-edge shadow, so a same-cycle write only reaches the shadow bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (commit_i) active_q <= shadow_q;
      if (we_i && (32'(addr_i) < TAPS)) shadow_q[addr_i] <= wdata_i;
    end
  end

  assign coef_o = active_q;

endmodule

// File: rtl/fir_pipelined_param.sv
// Transposed-form FIR with double-buffered coefficients, one-cycle latency and rounded,
// saturated output.
module fir_pipelined_param
  import fir_pkg::*;
#(
  parameter int unsigned TAPS      = DefTaps,
  parameter int unsigned DIN_W     = DefDinW,
  parameter int unsigned COEF_W    = DefCoefW,
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned OUT_SHIFT = DefOutShift,
  parameter int unsigned DOUT_W    = DefDoutW
) (
  input logic                  clk,
  input logic                  rst,
  fir_pipelined_param_if.slave bus
);

  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  prod [TAPS];
  logic signed [ACC_W-1:0]  p_q  [TAPS];
  logic signed [ACC_W-1:0]  p_d  [TAPS];
  logic signed [ACC_W-1:0]  y;
  rs_t                      rs;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;
  logic signed [DOUT_W-1:0] dout_q, dout_d;

  fir_coef_bank #(
    .TAPS  (TAPS),
    .COEF_W(COEF_W)
  ) u_coef_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.coef_we),
    .addr_i  (bus.coef_addr),
    .wdata_i (bus.coef_wdata),
    .commit_i(bus.coef_commit),
    .coef_o  (coef)
  );

  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      prod[k] = ACC_W'(bus.din) * ACC_W'(coef[k]);
    end
  end

  // y is the value p[0] takes on this sample, i.e. the filter output.
  assign y  = p_q[1] + prod[0];
  assign rs = round_sat(MaxW'(y), OUT_SHIFT, DOUT_W);

  always_comb begin
    p_d         = p_q;
    out_valid_d = 1'b0;
    dout_d      = dout_q;
    sat_d       = sat_q;
    if (bus.clear) begin
      for (int unsigned k = 0; k < TAPS; k++) p_d[k] = '0;
    end else if (bus.in_valid) begin
      for (int unsigned k = 0; k < TAPS - 1; k++) p_d[k] = p_q[k+1] + prod[k];
      p_d[TAPS-1] = prod[TAPS-1];
      out_valid_d = 1'b1;
      dout_d      = rs.val[DOUT_W-1:0];
      sat_d       = rs.sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < TAPS; k++) p_q[k] <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.sat_flag  = sat_q;

  // Upper bits of the clamped value are pure sign extension; p[0] is architectural state only.
  logic unused_bits;
  assign unused_bits = ^{rs.val[MaxW-1:DOUT_W], p_q[0]};

endmodule

// File: tb/tb_fir_pipelined_param.sv
// Bench for fir_pipelined_param: two 4-tap instances (OUT_SHIFT=0/DOUT_W=16 and
// OUT_SHIFT=1/DOUT_W=32) driven identically and compared with a convolution model.
module tb_fir_pipelined_param;

  localparam int unsigned TAPS   = 4;
  localparam int unsigned DIN_W  = 16;
  localparam int unsigned COEF_W = 32;
  localparam int unsigned AW     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_pipelined_param_if #(.TAPS(TAPS), .DIN_W(DIN_W), .COEF_W(COEF_W), .DOUT_W(16)) ifa ();
  fir_pipelined_param_if #(.TAPS(TAPS), .DIN_W(DIN_W), .COEF_W(COEF_W), .DOUT_W(32)) ifb ();

  fir_pipelined_param #(
    .TAPS(TAPS), .DIN_W(DIN_W), .COEF_W(COEF_W), .ACC_W(64), .OUT_SHIFT(0), .DOUT_W(16)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  fir_pipelined_param #(
    .TAPS(TAPS), .DIN_W(DIN_W), .COEF_W(COEF_W), .ACC_W(64), .OUT_SHIFT(1), .DOUT_W(32)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  int checks = 0;
  int errors = 0;

  // Model: each accepted sample remembers the coefficient set active when it arrived;
  // output n sums coefficient k of sample n-k times that sample.
  longint mx  [TAPS];
  longint mc  [TAPS][TAPS];
  longint act [TAPS];
  longint shd [TAPS];
  bit     exp_v;
  longint exp_a, exp_b;
  bit     sat_a, sat_b;

  function automatic void ref_rs(input longint y, input int sh, input int w,
                                 output longint v, output bit s);
    longint t, hi;
    t  = (sh > 0) ? ((y + (longint'(1) <<< (sh - 1))) >>> sh) : y;
    hi = (longint'(1) <<< (w - 1)) - 1;
    s  = (t > hi) || (t < -hi - 1);
    v  = (t > hi) ? hi : ((t < -hi - 1) ? -hi - 1 : t);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = 0; act[k] = 0; shd[k] = 0;
      for (int j = 0; j < TAPS; j++) mc[k][j] = 0;
    end
    exp_v = 0; exp_a = 0; exp_b = 0; sat_a = 0; sat_b = 0;
  endtask

  task automatic step(input bit v, input int d, input bit clr, input bit we, input int addr,
                      input longint wd, input bit cm);
    longint y;
    ifa.in_valid = v;  ifb.in_valid = v;
    ifa.din = DIN_W'(d);  ifb.din = DIN_W'(d);
    ifa.clear = clr;  ifb.clear = clr;
    ifa.coef_we = we;  ifb.coef_we = we;
    ifa.coef_addr = AW'(addr);  ifb.coef_addr = AW'(addr);
    ifa.coef_wdata = COEF_W'(wd);  ifb.coef_wdata = COEF_W'(wd);
    ifa.coef_commit = cm;  ifb.coef_commit = cm;
    @(posedge clk);
    if (clr) begin
      for (int k = 0; k < TAPS; k++) begin
        mx[k] = 0;
        for (int j = 0; j < TAPS; j++) mc[k][j] = 0;
      end
      exp_v = 0;
    end else if (v) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        mx[k] = mx[k-1];
        mc[k] = mc[k-1];
      end
      mx[0] = longint'($signed(DIN_W'(d)));
      mc[0] = act;
      y = 0;
      for (int k = 0; k < TAPS; k++) y += mc[k][k] * mx[k];
      ref_rs(y, 0, 16, exp_a, sat_a);
      ref_rs(y, 1, 32, exp_b, sat_b);
      exp_v = 1;
    end else begin
      exp_v = 0;
    end
    if (cm) act = shd;
    if (we) shd[addr] = wd;
    #1;
  endtask

  task automatic load_coefs(input longint c0, input longint c1, input longint c2,
                            input longint c3);
    step(0, 0, 0, 1, 0, c0, 0);
    step(0, 0, 0, 1, 1, c1, 0);
    step(0, 0, 0, 1, 2, c2, 0);
    step(0, 0, 0, 1, 3, c3, 0);
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.dout !== 16'd0 || ifa.sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: got v=%b d=%0d s=%b want 0 0 0", ifa.out_valid,
               $signed(ifa.dout), ifa.sat_flag);
    end
    checks++;
    if (ifb.out_valid !== 1'b0 || ifb.dout !== 32'd0 || ifb.sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: got v=%b d=%0d s=%b want 0 0 0", ifb.out_valid,
               $signed(ifb.dout), ifb.sat_flag);
    end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    int want [5] = '{1, 2, 3, 4, 0};
    load_coefs(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      step(1, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.dout !== 16'(want[i])) begin
        errors++;
        $display("FAIL impulse_a[%0d]: got v=%b d=%0d want v=1 d=%0d", i, ifa.out_valid,
                 $signed(ifa.dout), want[i]);
      end
      checks++;
      if (ifb.out_valid !== 1'b1 || ifb.dout !== 32'(exp_b)) begin
        errors++;
        $display("FAIL impulse_b[%0d]: got v=%b d=%0d want v=1 d=%0d", i, ifb.out_valid,
                 $signed(ifb.dout), exp_b);
      end
    end
  endtask

  task automatic test_gapped();
    int want [5] = '{1, 2, 3, 4, 0};
    for (int i = 0; i < 5; i++) begin
      step(1, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.dout !== 16'(want[i])) begin
        errors++;
        $display("FAIL gapped_a[%0d]: got v=%b d=%0d want v=1 d=%0d", i, ifa.out_valid,
                 $signed(ifa.dout), want[i]);
      end
      for (int g = 0; g < 2; g++) begin
        step(0, 5, 0, 0, 0, 0, 0);
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.dout !== 16'(want[i])) begin
          errors++;
          $display("FAIL gapped_idle[%0d]: got v=%b d=%0d want v=0 held d=%0d", i,
                   ifa.out_valid, $signed(ifa.dout), want[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int din_seq [4] = '{32767, 32767, -32768, -32768};
    load_coefs(32767, 32767, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, din_seq[i], 0, 0, 0, 0, 0);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.dout !== 16'(exp_a) || ifa.sat_flag !== sat_a) begin
        errors++;
        $display("FAIL sat_model_a[%0d]: got d=%0d s=%b want d=%0d s=%b", i, $signed(ifa.dout),
                 ifa.sat_flag, exp_a, sat_a);
      end
      checks++;
      if (ifb.dout !== 32'(exp_b) || ifb.sat_flag !== sat_b) begin
        errors++;
        $display("FAIL sat_model_b[%0d]: got d=%0d s=%b want d=%0d s=%b", i, $signed(ifb.dout),
                 ifb.sat_flag, exp_b, sat_b);
      end
      if (i == 1) begin
        checks++;
        if (ifa.dout !== 16'h7fff || ifa.sat_flag !== 1'b1) begin
          errors++;
          $display("FAIL sat_pos: got d=%0d s=%b want d=32767 s=1", $signed(ifa.dout),
                   ifa.sat_flag);
        end
      end
      if (i == 3) begin
        checks++;
        if (ifa.dout !== 16'h8000 || ifa.sat_flag !== 1'b1) begin
          errors++;
          $display("FAIL sat_neg: got d=%0d s=%b want d=-32768 s=1", $signed(ifa.dout),
                   ifa.sat_flag);
        end
      end
    end
  endtask

  task automatic test_rounding();
    load_coefs(3, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (ifb.out_valid !== 1'b1 || ifb.dout !== 32'd2 || ifb.sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL round_pos: got v=%b d=%0d s=%b want v=1 d=2 s=0", ifb.out_valid,
               $signed(ifb.dout), ifb.sat_flag);
    end
    checks++;
    if (ifa.dout !== 16'd3) begin
      errors++;
      $display("FAIL round_noshift: got d=%0d want d=3", $signed(ifa.dout));
    end
    step(1, -1, 0, 0, 0, 0, 0);
    checks++;
    if (ifb.out_valid !== 1'b1 || ifb.dout !== 32'hffff_ffff) begin
      errors++;
      $display("FAIL round_neg: got v=%b d=%0d want v=1 d=-1", ifb.out_valid, $signed(ifb.dout));
    end
  endtask

  task automatic test_commit();
    load_coefs(1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 5, 0);
    step(1, 2, 0, 0, 0, 0, 1);
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.dout !== 16'd2) begin
      errors++;
      $display("FAIL commit_old: got v=%b d=%0d want v=1 d=2", ifa.out_valid, $signed(ifa.dout));
    end
    step(1, 2, 0, 0, 0, 0, 0);
    checks++;
    if (ifa.dout !== 16'd10) begin
      errors++;
      $display("FAIL commit_new: got d=%0d want d=10", $signed(ifa.dout));
    end
    step(0, 0, 0, 1, 0, 9, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (ifa.dout !== 16'd5) begin
      errors++;
      $display("FAIL commit_samecycle_we: got d=%0d want d=5", $signed(ifa.dout));
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (ifa.dout !== 16'd9) begin
      errors++;
      $display("FAIL commit_shadow_kept: got d=%0d want d=9", $signed(ifa.dout));
    end
  endtask

  task automatic test_random();
    int     d, a;
    longint c;
    bit     v, clr, we, cm;
    for (int i = 0; i < 300; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      we  = ($urandom_range(0, 3) == 0);
      cm  = ($urandom_range(0, 15) == 0);
      d   = int'($urandom_range(0, 65535)) - 32768;
      a   = int'($urandom_range(0, TAPS - 1));
      c   = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 65535)) - 32768
                                         : longint'($urandom_range(0, 200)) - 100;
      step(v, d, clr, we, a, c, cm);
      checks++;
      if (ifa.out_valid !== exp_v || ifa.dout !== 16'(exp_a) || ifa.sat_flag !== sat_a) begin
        errors++;
        $display("FAIL random_a[%0d]: got v=%b d=%0d s=%b want v=%b d=%0d s=%b", i,
                 ifa.out_valid, $signed(ifa.dout), ifa.sat_flag, exp_v, exp_a, sat_a);
      end
      checks++;
      if (ifb.out_valid !== exp_v || ifb.dout !== 32'(exp_b) || ifb.sat_flag !== sat_b) begin
        errors++;
        $display("FAIL random_b[%0d]: got v=%b d=%0d s=%b want v=%b d=%0d s=%b", i,
                 ifb.out_valid, $signed(ifb.dout), ifb.sat_flag, exp_v, exp_b, sat_b);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int want [5] = '{7, 14, 21, 28, 28};
    load_coefs(1, 1, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 7, 0, 0, 0, 0, 0);
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.dout !== 16'd21) begin
      errors++;
      $display("FAIL prereset_stream: got v=%b d=%0d want v=1 d=21", ifa.out_valid,
               $signed(ifa.dout));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.dout !== 16'd0 || ifb.dout !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b da=%0d db=%0d want v=0 0 0", ifa.out_valid,
               $signed(ifa.dout), $signed(ifb.dout));
    end
    @(posedge clk);
    #1;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.dout !== 16'd0) begin
      errors++;
      $display("FAIL held_reset: got v=%b d=%0d want v=0 d=0", ifa.out_valid, $signed(ifa.dout));
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 7, 0, 0, 0, 0, 0);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.dout !== 16'd0) begin
        errors++;
        $display("FAIL coefs_zeroed[%0d]: got v=%b d=%0d want v=1 d=0", i, ifa.out_valid,
                 $signed(ifa.dout));
      end
    end
    load_coefs(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 7, 0, 0, 0, 0, 0);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.dout !== 16'(want[i])) begin
        errors++;
        $display("FAIL postreset_stream[%0d]: got v=%b d=%0d want v=1 d=%0d", i, ifa.out_valid,
                 $signed(ifa.dout), want[i]);
      end
    end
    step(1, 7, 1, 0, 0, 0, 0);
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.dout !== 16'd28) begin
      errors++;
      $display("FAIL clear_drop: got v=%b d=%0d want v=0 held d=28", ifa.out_valid,
               $signed(ifa.dout));
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 7, 0, 0, 0, 0, 0);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.dout !== 16'(want[i])) begin
        errors++;
        $display("FAIL postclear_stream[%0d]: got v=%b d=%0d want v=1 d=%0d", i, ifa.out_valid,
                 $signed(ifa.dout), want[i]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_impulse();
    test_gapped();
    test_saturation();
    test_rounding();
    test_commit();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
